// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one word per valid/ready handshake as start, data (LSB first), parity and stop bits.
module uart_tx_framer #(
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_RATE    = 100000000,
  parameter int WORD_WIDTH  = 8,
  parameter int EVEN_PARITY = 0,
  parameter int STOP_BITS   = 2
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] tx_data_in,
  input  logic                  tx_data_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy
);
  localparam int BAUD_DIV = CLK_RATE / BAUD_RATE;
  localparam int BW = $clog2(BAUD_DIV) + 1;
  localparam int NW = $clog2(WORD_WIDTH) + 1;
  localparam int SW = $clog2(STOP_BITS) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_baud;
  logic [NW-1:0] r_bit;
  logic [SW-1:0] r_stop;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic r_par, r_tx, w_tx, w_tick, w_take;
  assign w_tick = r_baud == BW'(BAUD_DIV - 1);
  assign w_take = r_state == IDLE && tx_data_valid;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = tx_data_valid ? START : IDLE;
      START:   w_next = w_tick ? DATA : START;
      DATA:    w_next = (w_tick && r_bit == NW'(WORD_WIDTH - 1)) ? PARITY : DATA;
      PARITY:  w_next = w_tick ? STOP : PARITY;
      STOP:    w_next = (w_tick && r_stop == SW'(STOP_BITS - 1)) ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
    // Line value for the coming cycle, so tx_out itself comes straight from a flop
    w_tx = 1'b1;
    case (w_next)
      START:   w_tx = 1'b0;
      DATA:    w_tx = (r_state == DATA && w_tick) ? r_shreg[1] : r_shreg[0];
      PARITY:  w_tx = r_par;
      default: w_tx = 1'b1;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx;
      r_baud  <= (r_state == IDLE || w_next != r_state || w_tick) ? '0 : r_baud + BW'(1);
      r_bit   <= r_state != DATA ? '0 : r_bit + NW'(w_tick);
      r_stop  <= r_state != STOP ? '0 : r_stop + SW'(w_tick);
      if (w_take) begin
        r_shreg <= tx_data_in;
        r_par   <= EVEN_PARITY != 0 ? ^tx_data_in : ~^tx_data_in;
      end else if (r_state == DATA && w_tick) begin
        r_shreg <= r_shreg >> 1;
      end
    end
  end
  assign tx_out   = r_tx;
  assign tx_ready = r_state == IDLE;
  assign tx_busy  = r_state != IDLE;
endmodule
